// File: rtl/divisor_salida_if.sv
// Bundle from the last division stage plus the result valid/ready stream.
// The divider output stage uses the slave modport; the producer and consumer use the master modport.
interface divisor_salida_if #(
    parameter int DVW = 16,
    parameter int DDW = 32,
    parameter int QW  = 32
);
    logic           goIn;
    logic [DVW-1:0] divisorIn;
    logic [DDW-1:0] dividendIn;
    logic [QW-1:0]  quotientIn;
    logic           negDivisorIn;
    logic           negDividendIn;
    logic           DivisorNoCeroIn;
    logic           readyIn;
    logic           validOut;
    logic [QW-1:0]  quotientOut;
    logic [DVW-1:0] remainderOut;
    logic           errOut;

    modport master (
        output goIn, divisorIn, dividendIn, quotientIn,
               negDivisorIn, negDividendIn, DivisorNoCeroIn, readyIn,
        input  validOut, quotientOut, remainderOut, errOut
    );

    modport slave (
        input  goIn, divisorIn, dividendIn, quotientIn,
               negDivisorIn, negDividendIn, DivisorNoCeroIn, readyIn,
        output validOut, quotientOut, remainderOut, errOut
    );
endinterface

// File: rtl/divisor_salida.sv
// Divider output stage: sign correction, divide-by-zero handling and a drain FIFO.
// Signed correction is enabled by defining DIV_SALIDA_SIGNO_EN; otherwise the results pass through unsigned.
module divisor_salida #(
    parameter int DVW   = 16,
    parameter int DDW   = 32,
    parameter int QW    = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    divisor_salida_if.slave            bus,
    input  logic                       clrOverflow,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [QW-1:0]  mem_q [DEPTH];
    logic [DVW-1:0] mem_r [DEPTH];
    logic           mem_err [DEPTH];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [CW-1:0]  count_r;
    logic           overflow_r;

    logic [QW-1:0]  entry_q;
    logic [DVW-1:0] entry_r;
    logic           entry_err;
    logic           valid;
    logic           is_full;
    logic           push;
    logic           pop;
    logic           drop;

    // The divisor field and the upper dividend bits travel with the bundle but carry no result data.
    logic unused_bits;
    assign unused_bits = ^{bus.divisorIn, bus.dividendIn, bus.negDivisorIn, bus.negDividendIn};

    // A zero divisor overrides every sign rule.
    always_comb begin
        entry_q   = bus.quotientIn;
        entry_r   = bus.dividendIn[DVW-1:0];
        entry_err = 1'b0;
`ifdef DIV_SALIDA_SIGNO_EN
        if (bus.negDividendIn ^ bus.negDivisorIn)
            entry_q = -bus.quotientIn;
        if (bus.negDividendIn)
            entry_r = -bus.dividendIn[DVW-1:0];
`endif
        if (!bus.DivisorNoCeroIn) begin
            entry_q   = '1;
            entry_r   = '0;
            entry_err = 1'b1;
        end
    end

    assign valid   = (count_r != '0);
    assign is_full = (count_r == CW'(DEPTH));
    assign pop     = valid && bus.readyIn;
    assign push    = bus.goIn && (!is_full || pop);
    assign drop    = bus.goIn && is_full && !pop;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i]   <= '0;
                mem_r[i]   <= '0;
                mem_err[i] <= 1'b0;
            end
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_r    <= '0;
            overflow_r <= 1'b0;
        end else begin
            if (push) begin
                mem_q[wr_ptr]   <= entry_q;
                mem_r[wr_ptr]   <= entry_r;
                mem_err[wr_ptr] <= entry_err;
                wr_ptr          <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
            // A drop in the same cycle as a clear must leave the flag set.
            if (drop)
                overflow_r <= 1'b1;
            else if (clrOverflow)
                overflow_r <= 1'b0;
        end
    end

    assign bus.validOut     = valid;
    assign bus.quotientOut  = mem_q[rd_ptr];
    assign bus.remainderOut = mem_r[rd_ptr];
    assign bus.errOut       = mem_err[rd_ptr];
    assign full             = is_full;
    assign count            = count_r;
    assign overflow         = overflow_r;
endmodule
